// File: rtl/instr_decode_queue.sv
// -----------------------------------------------------------------------------
// instr_decode_queue
//
// Buffered MIPS-32 instruction field splitter that sits between instruction
// fetch and the register-file/control stage. Instruction words arrive over a
// valid/ready handshake and are held in a DEPTH-entry FIFO. The head entry is
// split into every MIPS field, classified as an R, I or J format, and its
// immediate is extended to IMM_W bits. A flush discards everything buffered,
// which is used for branch/jump redirects.
//
// Parameters
//   DEPTH  FIFO entries (power of two, >= 2)
//   IMM_W  width of the extended immediate (>= 16)
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   upstream presents in_instr
//   in_ready   queue can accept a word (!full, registered state only)
//   in_instr   32-bit instruction word
//   flush      discard all entries at the next edge
//   out_valid  head entry present (!empty, registered state only)
//   out_ready  downstream consumes the head entry
//   opcode     head[31:26]
//   rs         head[25:21]
//   rt         head[20:16]
//   rd         head[15:11]
//   shamt      head[10:6]
//   funct      head[5:0]
//   imm_ext    head[15:0], zero-extended for andi/ori/xori, else sign-extended
//   address    head[25:0] (jump target field)
//   itype      format class: 0 = R, 1 = I, 2 = J, 3 = reserved
//   count      current occupancy
//
// All field outputs and itype are forced to zero while out_valid is low.
// -----------------------------------------------------------------------------
module instr_decode_queue #(
    parameter int DEPTH = 4,
    parameter int IMM_W = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [31:0]                  in_instr,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [5:0]                   opcode,
    output logic [4:0]                   rs,
    output logic [4:0]                   rt,
    output logic [4:0]                   rd,
    output logic [4:0]                   shamt,
    output logic [5:0]                   funct,
    output logic [IMM_W-1:0]             imm_ext,
    output logic [25:0]                  address,
    output logic [1:0]                   itype,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    // Opcodes that drive the format class and immediate extension.
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;

    typedef enum logic [1:0] {
        ITYPE_R    = 2'd0,
        ITYPE_I    = 2'd1,
        ITYPE_J    = 2'd2,
        ITYPE_RSVD = 2'd3
    } itype_e;

    // -------------------------------------------------------------------------
    // Storage and pointers
    // -------------------------------------------------------------------------
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] occ;

    logic push;
    logic pop;

    // Handshake flags come only from the occupancy register so that neither
    // side sees a combinational path through the other side's signals.
    assign in_ready  = (occ != FULL_COUNT);
    assign out_valid = (occ != '0);
    assign count     = occ;

    // A flush cycle suppresses both transfers; the offered word is dropped.
    assign push = in_valid  && in_ready  && !flush;
    assign pop  = out_valid && out_ready && !flush;

    // NOTE: state uses <= so every register samples pre-edge values; mixing in
    // blocking assignments here would make the result depend on block order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            // DEPTH is a power of two, so the natural AW-bit wrap is modulo DEPTH.
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   occ <= occ + CW'(1);
                2'b01:   occ <= occ - CW'(1);
                default: occ <= occ;
            endcase
        end
    end

    // NOTE: the array has no reset; its contents are only observed through
    // occ/rd_ptr, which are reset, so clearing it would be wasted logic.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_instr;
    end

    // -------------------------------------------------------------------------
    // Head decode
    // -------------------------------------------------------------------------
    logic [31:0] head;
    logic [5:0]  head_op;
    itype_e      head_type;
    logic        head_zext;

    assign head    = mem[rd_ptr];
    assign head_op = head[31:26];

    always_comb begin
        unique case (head_op)
            OP_SPECIAL:     head_type = ITYPE_R;
            OP_J, OP_JAL:   head_type = ITYPE_J;
            default:        head_type = ITYPE_I;
        endcase
    end

    // Logical immediates are unsigned; everything else treats imm as signed.
    assign head_zext = (head_op == OP_ANDI) || (head_op == OP_ORI) ||
                       (head_op == OP_XORI);

    // NOTE: every output gets a default before the conditional, otherwise the
    // out_valid=0 path would leave them unassigned and infer latches.
    always_comb begin
        opcode  = '0;
        rs      = '0;
        rt      = '0;
        rd      = '0;
        shamt   = '0;
        funct   = '0;
        imm_ext = '0;
        address = '0;
        itype   = '0;
        if (out_valid) begin
            opcode  = head_op;
            rs      = head[25:21];
            rt      = head[20:16];
            rd      = head[15:11];
            shamt   = head[10:6];
            funct   = head[5:0];
            address = head[25:0];
            itype   = head_type;
            imm_ext = head_zext ? IMM_W'(head[15:0])
                                : IMM_W'($signed(head[15:0]));
        end
    end

endmodule

// File: tb/tb_instr_decode_queue.sv
// -----------------------------------------------------------------------------
// tb_instr_decode_queue
//
// Self-checking bench for instr_decode_queue. A queue of words is the
// reference model; expected outputs are derived from the MIPS field layout,
// format rules and immediate-extension rules applied to the model's head.
// -----------------------------------------------------------------------------
module tb_instr_decode_queue;

    localparam int DEPTH = 4;
    localparam int IMM_W = 32;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [5:0]       opcode;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic [4:0]       rd;
    logic [4:0]       shamt;
    logic [5:0]       funct;
    logic [IMM_W-1:0] imm_ext;
    logic [25:0]      address;
    logic [1:0]       itype;
    logic [CW-1:0]    count;

    int total = 0;
    int bad   = 0;

    logic [31:0] model_q[$];

    typedef struct packed {
        logic             ov;
        logic             ir;
        logic [CW-1:0]    cnt;
        logic [5:0]       op;
        logic [4:0]       rs;
        logic [4:0]       rt;
        logic [4:0]       rd;
        logic [4:0]       sh;
        logic [5:0]       fn;
        logic [IMM_W-1:0] imm;
        logic [25:0]      addr;
        logic [1:0]       it;
    } view_t;

    instr_decode_queue #(.DEPTH(DEPTH), .IMM_W(IMM_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .opcode    (opcode),
        .rs        (rs),
        .rt        (rt),
        .rd        (rd),
        .shamt     (shamt),
        .funct     (funct),
        .imm_ext   (imm_ext),
        .address   (address),
        .itype     (itype),
        .count     (count)
    );

    always #5 clk = ~clk;

    // Expected outputs from the model queue.
    function automatic view_t exp_view();
        view_t       v;
        logic [31:0] w;
        int          op;
        v     = '0;
        v.ir  = (model_q.size() < DEPTH);
        v.cnt = CW'(model_q.size());
        if (model_q.size() != 0) begin
            w      = model_q[0];
            op     = int'(w >> 26);
            v.ov   = 1'b1;
            v.op   = 6'(op);
            v.rs   = 5'((w >> 21) & 32'h1F);
            v.rt   = 5'((w >> 16) & 32'h1F);
            v.rd   = 5'((w >> 11) & 32'h1F);
            v.sh   = 5'((w >> 6) & 32'h1F);
            v.fn   = 6'(w & 32'h3F);
            v.addr = 26'(w & 32'h03FF_FFFF);
            if (op == 0)                 v.it = 2'd0;
            else if (op == 2 || op == 3) v.it = 2'd2;
            else                         v.it = 2'd1;
            if (op == 12 || op == 13 || op == 14)
                v.imm = IMM_W'(w & 32'hFFFF);
            else if ((w & 32'h8000) != 0)
                v.imm = ~IMM_W'(0) ^ IMM_W'(16'hFFFF ^ (w & 32'hFFFF));
            else
                v.imm = IMM_W'(w & 32'hFFFF);
        end
        return v;
    endfunction

    function automatic view_t dut_view();
        view_t v;
        v.ov   = out_valid;
        v.ir   = in_ready;
        v.cnt  = count;
        v.op   = opcode;
        v.rs   = rs;
        v.rt   = rt;
        v.rd   = rd;
        v.sh   = shamt;
        v.fn   = funct;
        v.imm  = imm_ext;
        v.addr = address;
        v.it   = itype;
        return v;
    endfunction

    // Drive one cycle of stimulus, advance the model, and return #1 after the edge.
    task automatic cycle(input logic iv, input logic [31:0] ins,
                         input logic ordy, input logic fl);
        bit do_push;
        bit do_pop;
        in_valid  = iv;
        in_instr  = ins;
        out_ready = ordy;
        flush     = fl;
        do_push = iv && (model_q.size() < DEPTH) && !fl;
        do_pop  = ordy && (model_q.size() > 0) && !fl;
        @(posedge clk);
        if (fl) begin
            model_q.delete();
        end else begin
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back(ins);
        end
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic test_reset();
        view_t e;
        view_t g;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_instr  = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        model_q.delete();
        repeat (2) @(posedge clk);
        #1;
        e = exp_view();
        g = dut_view();
        total++;
        if (g !== e) begin
            bad++;
            $display("FAIL reset_state: got %h expected %h", g, e);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        g = dut_view();
        total++;
        if (g !== e) begin
            bad++;
            $display("FAIL reset_release: got %h expected %h", g, e);
        end
    endtask

    task automatic test_fields();
        view_t g;
        cycle(1'b1, 32'h014B4820, 1'b0, 1'b0);
        total++;
        if ({out_valid, opcode, rs, rt, rd, shamt, funct, itype, count} !==
            {1'b1, 6'd0, 5'd10, 5'd11, 5'd9, 5'd0, 6'h20, 2'd0, CW'(1)}) begin
            bad++;
            $display("FAIL add_fields: got ov=%0b op=%h rs=%0d rt=%0d rd=%0d sh=%0d fn=%h it=%0d cnt=%0d expected 1/00/10/11/9/0/20/0/1",
                     out_valid, opcode, rs, rt, rd, shamt, funct, itype, count);
        end
        cycle(1'b0, '0, 1'b1, 1'b0);

        cycle(1'b1, 32'h2128FFFF, 1'b0, 1'b0);
        total++;
        if ({imm_ext, rs, rt, itype} !== {32'hFFFF_FFFF, 5'd9, 5'd8, 2'd1}) begin
            bad++;
            $display("FAIL addi_fields: got imm=%h rs=%0d rt=%0d it=%0d expected ffffffff/9/8/1",
                     imm_ext, rs, rt, itype);
        end
        cycle(1'b0, '0, 1'b1, 1'b0);

        cycle(1'b1, 32'h3528FFFF, 1'b0, 1'b0);
        total++;
        if ({imm_ext, opcode, itype} !== {32'h0000_FFFF, 6'h0D, 2'd1}) begin
            bad++;
            $display("FAIL ori_fields: got imm=%h op=%h it=%0d expected 0000ffff/0d/1",
                     imm_ext, opcode, itype);
        end
        cycle(1'b0, '0, 1'b1, 1'b0);

        cycle(1'b1, 32'h08100000, 1'b0, 1'b0);
        total++;
        if ({opcode, address, itype} !== {6'h02, 26'h0100000, 2'd2}) begin
            bad++;
            $display("FAIL j_fields: got op=%h addr=%h it=%0d expected 02/0100000/2",
                     opcode, address, itype);
        end
        cycle(1'b0, '0, 1'b1, 1'b0);

        cycle(1'b1, 32'h0C000010, 1'b0, 1'b0);
        total++;
        if ({opcode, itype} !== {6'h03, 2'd2}) begin
            bad++;
            $display("FAIL jal_fields: got op=%h it=%0d expected 03/2", opcode, itype);
        end
        cycle(1'b0, '0, 1'b1, 1'b0);
        g = dut_view();
        total++;
        if (g !== exp_view()) begin
            bad++;
            $display("FAIL fields_empty: got %h expected %h", g, exp_view());
        end
    endtask

    // Fill to DEPTH with out_ready low (pointers start mid-array so they wrap),
    // offer one extra word, then drain and confirm order.
    task automatic test_full();
        logic [31:0] words[DEPTH];
        view_t       g;
        for (int i = 0; i < DEPTH; i++) begin
            words[i] = $urandom;
            cycle(1'b1, words[i], 1'b0, 1'b0);
            g = dut_view();
            total++;
            if (g !== exp_view()) begin
                bad++;
                $display("FAIL fill_%0d: got %h expected %h", i, g, exp_view());
            end
        end
        total++;
        if ({count, in_ready} !== {CW'(DEPTH), 1'b0}) begin
            bad++;
            $display("FAIL full_flags: got cnt=%0d ir=%0b expected %0d/0", count, in_ready, DEPTH);
        end
        cycle(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        total++;
        if ({count, in_ready, opcode, address} !== {CW'(DEPTH), 1'b0, words[0]}) begin
            bad++;
            $display("FAIL full_refuse: got cnt=%0d ir=%0b head=%h expected %0d/0/%h",
                     count, in_ready, {opcode, address}, DEPTH, words[0]);
        end
        for (int i = 0; i < DEPTH; i++) begin
            total++;
            if ({out_valid, opcode, address} !== {1'b1, words[i]}) begin
                bad++;
                $display("FAIL drain_%0d: got ov=%0b head=%h expected 1/%h",
                         i, out_valid, {opcode, address}, words[i]);
            end
            cycle(1'b0, '0, 1'b1, 1'b0);
        end
        total++;
        if ({out_valid, in_ready, count} !== {1'b0, 1'b1, CW'(0)}) begin
            bad++;
            $display("FAIL drain_empty: got ov=%0b ir=%0b cnt=%0d expected 0/1/0",
                     out_valid, in_ready, count);
        end
    endtask

    task automatic test_flush();
        view_t g;
        view_t e;
        cycle(1'b1, 32'h11112222, 1'b0, 1'b0);
        cycle(1'b1, 32'h33334444, 1'b0, 1'b0);
        total++;
        if (count !== CW'(2)) begin
            bad++;
            $display("FAIL flush_pre: got cnt=%0d expected 2", count);
        end
        cycle(1'b1, 32'h2108ABCD, 1'b1, 1'b1);
        e    = '0;
        e.ir = 1'b1;
        g    = dut_view();
        total++;
        if (g !== e) begin
            bad++;
            $display("FAIL flush_clear: got %h expected %h", g, e);
        end
        cycle(1'b1, 32'h8C42_0004, 1'b0, 1'b0);
        total++;
        if ({count, opcode, address} !== {CW'(1), 32'h8C42_0004}) begin
            bad++;
            $display("FAIL flush_dropped: got cnt=%0d head=%h expected 1/8c420004",
                     count, {opcode, address});
        end
        cycle(1'b0, '0, 1'b1, 1'b0);
    endtask

    // Streaming push+pop at count=1, then asynchronous reset mid-stream.
    task automatic test_back_to_back();
        logic [31:0] sent[$];
        logic [31:0] w;
        int          rd_idx;
        rd_idx = 0;
        w = $urandom;
        sent.push_back(w);
        cycle(1'b1, w, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            total++;
            if ({count, out_valid, opcode, address} !== {CW'(1), 1'b1, sent[rd_idx]}) begin
                bad++;
                $display("FAIL stream_%0d: got cnt=%0d ov=%0b head=%h expected 1/1/%h",
                         i, count, out_valid, {opcode, address}, sent[rd_idx]);
            end
            w = $urandom;
            sent.push_back(w);
            cycle(1'b1, w, 1'b1, 1'b0);
            rd_idx++;
        end
        #2;
        reset = 1'b1;
        #1;
        model_q.delete();
        total++;
        if ({out_valid, in_ready, count, opcode, address, itype} !== {1'b0, 1'b1, CW'(0), 34'd0}) begin
            bad++;
            $display("FAIL async_reset: got ov=%0b ir=%0b cnt=%0d head=%h it=%0d expected 0/1/0/0/0",
                     out_valid, in_ready, count, {opcode, address}, itype);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        logic [5:0]  ops[8];
        logic [31:0] w;
        view_t       g;
        view_t       e;
        int          errs;
        errs = 0;
        ops = '{6'h00, 6'h02, 6'h03, 6'h0C, 6'h0D, 6'h0E, 6'h08, 6'h23};
        for (int i = 0; i < 400; i++) begin
            w = $urandom;
            if ($urandom_range(3) != 0) w[31:26] = ops[$urandom_range(7)];
            cycle(1'($urandom_range(1)), w, 1'($urandom_range(1)),
                  1'($urandom_range(15) == 0));
            g = dut_view();
            e = exp_view();
            total++;
            if (g !== e) begin
                bad++;
                if (errs < 10)
                    $display("FAIL random_%0d: got %h expected %h", i, g, e);
                errs++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_fields();
        test_full();
        test_flush();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_decode_queue.md
# instr_decode_queue

Buffered, parametrised instruction field splitter for the MIPS-32 datapath, placed between instruction fetch and the register-file/control stage. It accepts 32-bit instruction words over a valid/ready handshake and holds them in a DEPTH-entry FIFO. For the head entry it presents every MIPS field (opcode, rs, rt, rd, shamt, funct, extended immediate, jump address) plus a format class. A flush input discards all buffered instructions for branch/jump redirects.

## Interface
- DEPTH, 4, FIFO entries; power of two, minimum 2
- IMM_W, 32, width of extended immediate output; minimum 16
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream presents in_instr
- in_ready  out  1  queue can accept a word; equals !full and is purely registered-state based
- in_instr  in  32  instruction word
- flush  in  1  discard all entries
- out_valid  out  1  head entry present (!empty)
- out_ready  in  1  downstream consumes head
- opcode  out  6  head[31:26]
- rs  out  5  head[25:21]
- rt  out  5  head[20:16]
- rd  out  5  head[15:11]
- shamt  out  5  head[10:6]
- funct  out  6  head[5:0]
- imm_ext  out  IMM_W  head[15:0], sign- or zero-extended
- address  out  26  head[25:0]
- itype  out  2  0 = R, 1 = I, 2 = J, 3 = reserved/unused
- count  out  $clog2(DEPTH+1)  occupancy

## Operation
- Storage: DEPTH×32 array, write pointer, read pointer, occupancy counter. Pointers wrap modulo DEPTH.
- Push: in_valid && in_ready && !flush. Writes in_instr at wr_ptr, then wr_ptr+1.
- Pop: out_valid && out_ready && !flush. Advances rd_ptr.
- Simultaneous push and pop: both occur and count is unchanged. When full, a push is refused (in_ready=0) even if a pop happens that cycle.
- Flush: next edge sets count=0 and wr_ptr=rd_ptr=0. Any push or pop in the same cycle is ignored, and the word offered that cycle is dropped.
- Field outputs are combinational from the head entry. While out_valid=0, all field outputs and itype are driven to 0.
- itype:
  - opcode 0x00 → R.
  - opcode 0x02 or 0x03 → J.
  - All other opcodes → I.
- imm_ext:
  - opcode 0x0C, 0x0D or 0x0E (andi/ori/xori) → zero-extend head[15:0] to IMM_W.
  - Otherwise → sign-extend head[15] to IMM_W.
- Fields are extracted in every format. Downstream selects the relevant fields by itype.

## Timing
- Reset (async assert, sync release at next edge):
  - count=0, pointers=0.
  - out_valid=0, in_ready=1.
  - All field outputs and itype = 0.
  - Array contents don't-care.
- Latency: a word pushed at edge N is visible on the outputs with out_valid=1 after edge N, provided the queue was empty.
- Throughput: one push and one pop per cycle sustained.
- Full: count==DEPTH, in_ready=0. Empty: count==0, out_valid=0. A pop when empty and a push when full are no-ops.
- Reset mid-operation discards everything immediately (asynchronous).
- in_ready and out_valid do not depend combinationally on in_valid, out_ready or flush.

## Test plan
- Reset, then push 0x014B4820 → next cycle: out_valid=1, opcode=0, rs=10, rt=11, rd=9, shamt=0, funct=0x20, itype=0, count=1.
- Push 0x2128FFFF (addi) → imm_ext=0xFFFFFFFF, rs=9, rt=8, itype=1. Pop, then push 0x3528FFFF (ori) → imm_ext=0x0000FFFF, opcode=0x0D.
- Push 0x08100000 → opcode=2, address=0x0100000, itype=2. Push 0x0C000010 → opcode=3, itype=2.
- With out_ready=0, push DEPTH words → count=DEPTH, in_ready=0, and an extra offered word is not stored. Then drain with out_ready=1 → words emerge in order and pointers wrap correctly.
- With count=2, assert flush together with in_valid=1 and out_ready=1 → next cycle count=0, out_valid=0, fields=0, and the offered word is absent.
- Hold in_valid=out_ready=1 at count=1 for 10 cycles → count stays at 1 and output order matches input order. Assert reset mid-stream → out_valid drops immediately and count=0.
